// File: rtl/mult_sequencer_if.sv
// Multiply request/result and shared-adder bundle for mult_sequencer.
interface mult_sequencer_if #(
  parameter int unsigned N = 32
);
  logic         Start;
  logic         Signed;
  logic [N-1:0] SrcA;
  logic [N-1:0] SrcB;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Hi;
  logic [N-1:0] Lo;
  logic [N-1:0] AddA;
  logic [N-1:0] AddB;
  logic         AddCin;
  logic [N-1:0] AddSum;
  logic         AddC;

  // Requester plus external adder side
  modport master (
    output Start, Signed, SrcA, SrcB, AddSum, AddC,
    input  Busy, Done, Hi, Lo, AddA, AddB, AddCin
  );

  // Sequencer side
  modport slave (
    input  Start, Signed, SrcA, SrcB, AddSum, AddC,
    output Busy, Done, Hi, Lo, AddA, AddB, AddCin
  );
endinterface

// File: rtl/mult_sequencer.sv
// Multi-cycle mult/multu sequencer driving one shared external N-bit adder.
module mult_sequencer #(
  parameter int unsigned N = 32
) (
  input logic             clk,
  input logic             reset_n,
  mult_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEGA  = 3'd1,
    S_NEGB  = 3'd2,
    S_MUL   = 3'd3,
    S_NEGLO = 3'd4,
    S_NEGHI = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  mcand;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [CW-1:0] count;
  logic          neg_a;
  logic          neg_b;
  logic          neg_res;
  logic          carry_lo;
  logic          neg_a_in;
  logic          neg_b_in;
  logic          last_mul;
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic          add_cin;
  logic          busy;
  logic          done;

  assign neg_a_in = bus.Signed & bus.SrcA[N-1];
  assign neg_b_in = bus.Signed & bus.SrcB[N-1];
  assign last_mul = (count == CW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.Start) state_next = neg_a_in ? S_NEGA : (neg_b_in ? S_NEGB : S_MUL);
      S_NEGA:  state_next = neg_b ? S_NEGB : S_MUL;
      S_NEGB:  state_next = S_MUL;
      S_MUL:   if (last_mul) state_next = neg_res ? S_NEGLO : S_DONE;
      S_NEGLO: state_next = S_NEGHI;
      S_NEGHI: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Adder drive and status outputs, decoded from state and registers
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    case (state)
      S_NEGA: begin
        add_a   = ~mcand;
        add_cin = 1'b1;
      end
      S_NEGB, S_NEGLO: begin
        add_a   = ~lo;
        add_cin = 1'b1;
      end
      S_MUL: begin
        add_a = hi;
        add_b = lo[0] ? mcand : '0;
      end
      S_NEGHI: begin
        add_a   = ~hi;
        add_cin = carry_lo;
      end
      default: ;
    endcase
  end

  // Operand, product and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      neg_res  <= 1'b0;
      carry_lo <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            mcand   <= bus.SrcA;
            lo      <= bus.SrcB;
            hi      <= '0;
            count   <= '0;
            neg_a   <= neg_a_in;
            neg_b   <= neg_b_in;
            neg_res <= neg_a_in ^ neg_b_in;
          end
        end
        S_NEGA: mcand <= bus.AddSum;
        S_NEGB: lo <= bus.AddSum;
        S_MUL: begin
          // Carry-out is bit N of the partial sum; it becomes the new Hi MSB
          hi    <= {bus.AddC, bus.AddSum[N-1:1]};
          lo    <= {bus.AddSum[0], lo[N-1:1]};
          count <= count + CW'(1);
        end
        S_NEGLO: begin
          lo       <= bus.AddSum;
          carry_lo <= bus.AddC;
        end
        S_NEGHI: hi <= bus.AddSum;
        default: ;
      endcase
    end
  end

  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.Hi     = hi;
  assign bus.Lo     = lo;
  assign bus.AddA   = add_a;
  assign bus.AddB   = add_b;
  assign bus.AddCin = add_cin;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer with a behavioural adder and product model.
module tb_mult_sequencer;

  localparam int unsigned N = 32;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  mult_sequencer_if #(.N(N)) bus ();

  mult_sequencer #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // External ripple-carry adder stand-in
  assign {bus.AddC, bus.AddSum} = 33'(bus.AddA) + 33'(bus.AddB) + 33'(bus.AddCin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full 2N-bit product by plain extended multiplication
  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int  lat;
    bit  na;
    bit  nb;
    na  = sgn & a[31];
    nb  = sgn & b[31];
    lat = N + 1;
    if (na) lat++;
    if (nb) lat++;
    if (na ^ nb) lat += 2;
    return lat;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // One multiply; optional stray Start while busy and/or in the Done cycle
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int inject, input bit start_at_done);
    logic [63:0] exp;
    int          cyc;
    bit          busy_ok;
    exp = ref_prod(sgn, a, b);
    @(negedge clk);
    check({tag, " idle_busy"}, 64'(bus.Busy), 64'(1'b0));
    bus.Start  = 1'b1;
    bus.Signed = sgn;
    bus.SrcA   = a;
    bus.SrcB   = b;
    @(negedge clk);
    bus.Start  = 1'b0;
    bus.Signed = 1'($urandom);
    bus.SrcA   = 32'($urandom);
    bus.SrcB   = 32'($urandom);
    cyc     = 1;
    busy_ok = 1'b1;
    while (bus.Done !== 1'b1 && cyc < 200) begin
      if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
      bus.Start = (cyc == inject);
      if (bus.Start) begin
        bus.Signed = 1'($urandom);
        bus.SrcA   = pick();
        bus.SrcB   = pick();
      end
    end
    check({tag, " done_seen"}, 64'(bus.Done), 64'(1'b1));
    check({tag, " latency"}, 64'(cyc), 64'(ref_lat(sgn, a, b)));
    check({tag, " busy_run"}, 64'(busy_ok & bus.Busy), 64'(1'b1));
    check({tag, " hi"}, 64'(bus.Hi), 64'(exp[63:32]));
    check({tag, " lo"}, 64'(bus.Lo), 64'(exp[31:0]));
    bus.Start = start_at_done;
    @(negedge clk);
    bus.Start = 1'b0;
    check({tag, " done_pulse"}, 64'(bus.Done), 64'(1'b0));
    check({tag, " busy_fall"}, 64'(bus.Busy), 64'(1'b0));
    check({tag, " hold"}, {32'(bus.Hi), 32'(bus.Lo)}, exp);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset_n    = 1'b1;
    bus.Start  = 1'b0;
    bus.Signed = 1'b0;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst busy", 64'(bus.Busy), 64'(1'b0));
    check("rst done", 64'(bus.Done), 64'(1'b0));
    check("rst hilo", {32'(bus.Hi), 32'(bus.Lo)}, 64'h0);
    check("rst adder", {31'(bus.AddA), 32'(bus.AddB), 1'(bus.AddCin)}, 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("multu7x6", 1'b0, 32'd7, 32'd6, 0, 1'b0);
    run_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
    run_op("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    run_op("mult_5xm3", 1'b1, 32'd5, 32'hFFFF_FFFD, 0, 1'b0);
    run_op("mult_zero", 1'b1, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("busy_start", 1'b0, 32'd7, 32'd6, 10, 1'b0);
    run_op("done_start", 1'b1, 32'hFFFF_FFF0, 32'h0000_1234, 0, 1'b1);

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Signed = 1'b0;
    bus.SrcA   = 32'd7;
    bus.SrcB   = 32'd6;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (14) @(negedge clk);
    check("midrst busy_before", 64'(bus.Busy), 64'(1'b1));
    reset_n = 1'b0;
    #1;
    check("midrst busy", 64'(bus.Busy), 64'(1'b0));
    check("midrst hilo", {32'(bus.Hi), 32'(bus.Lo)}, 64'h0);
    check("midrst adder", {31'(bus.AddA), 32'(bus.AddB), 1'(bus.AddCin)}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_rst 2x3", 1'b0, 32'd2, 32'd3, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)), pick(), pick(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0,
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
